// File: rtl/axi_common_pkg.sv
// Shared AXI4 types and constants used by the slave adapters, the native bridges
// and the burst address generator.
package axi_common;

   localparam int unsigned PAGE_BITS = 12;

   typedef logic [7:0] len_t;
   typedef logic [2:0] size_t;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'b00,
      BURST_INCR  = 2'b01,
      BURST_WRAP  = 2'b10,
      BURST_RSVD  = 2'b11
   } burst_t;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } resp_t;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } abg_state_t;

endpackage

// File: rtl/axi_burst_next_addr.sv
// Combinational next-beat address for FIXED, INCR and WRAP bursts.
// Reserved burst encodings step as INCR.
module axi_burst_next_addr
   import axi_common::*;
#(
   parameter int unsigned AddrWidth = 64
) (
   input  logic [AddrWidth-1:0] addr_i,
   input  len_t                 len_i,
   input  size_t                size_i,
   input  burst_t               burst_i,
   output logic [AddrWidth-1:0] next_addr_o
);

   logic [AddrWidth-1:0] w_step;
   logic [AddrWidth-1:0] w_size_mask;
   logic [AddrWidth-1:0] w_wrap_mask;
   logic [AddrWidth-1:0] w_incr_addr;
   logic [AddrWidth-1:0] w_wrap_addr;

   assign w_step      = AddrWidth'(1) << size_i;
   assign w_size_mask = w_step - AddrWidth'(1);
   assign w_wrap_mask = ((AddrWidth'(len_i) + AddrWidth'(1)) << size_i) - AddrWidth'(1);
   assign w_incr_addr = (addr_i & ~w_size_mask) + w_step;
   // Wrap keeps the bits above the container and increments within it.
   assign w_wrap_addr = (addr_i & ~w_wrap_mask) | ((addr_i + w_step) & w_wrap_mask);

   always_comb begin
      next_addr_o = w_incr_addr;
      case (burst_i)
         BURST_FIXED: next_addr_o = addr_i;
         BURST_WRAP:  next_addr_o = w_wrap_addr;
         default:     next_addr_o = w_incr_addr;
      endcase
   end

endmodule

// File: rtl/axi_burst_addr_gen.sv
// AXI4 burst address generator: accepts one AW/AR-style command and streams one
// address per beat, flagging protocol-illegal commands for the whole burst.
module axi_burst_addr_gen
   import axi_common::*;
#(
   parameter int unsigned AddrWidth = 64,
   parameter int unsigned DataWidth = 64,
   parameter int unsigned CheckPage = 1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 cmd_valid_i,
   output logic                 cmd_ready_o,
   input  logic [AddrWidth-1:0] cmd_addr_i,
   input  logic [7:0]           cmd_len_i,
   input  logic [2:0]           cmd_size_i,
   input  logic [1:0]           cmd_burst_i,
   output logic                 beat_valid_o,
   input  logic                 beat_ready_i,
   output logic [AddrWidth-1:0] beat_addr_o,
   output logic [7:0]           beat_idx_o,
   output logic                 beat_last_o,
   output logic                 beat_err_o
);

   localparam int unsigned MaxSize = $clog2(DataWidth / 8);

   abg_state_t           r_state, w_state_d;
   logic                 r_valid, w_valid_d;
   logic [AddrWidth-1:0] r_addr,  w_addr_d;
   len_t                 r_idx,   w_idx_d;
   logic                 r_last,  w_last_d;
   logic                 r_err,   w_err_d;
   len_t                 r_len,   w_len_d;
   size_t                r_size,  w_size_d;
   burst_t               r_burst, w_burst_d;

   logic                 w_cmd_ready;
   logic                 w_cmd_fire;
   logic                 w_beat_fire;
   logic [AddrWidth-1:0] w_next_addr;

   burst_t               w_cmd_burst;
   logic [AddrWidth-1:0] w_cmd_size_mask;
   logic [AddrWidth-1:0] w_cmd_last_byte;
   logic                 w_wrap_len_ok;
   logic                 w_cmd_aligned;
   logic                 w_wrap_bad;
   logic                 w_page_err;
   logic                 w_cmd_err;
   burst_t               w_step_burst;

   // Command legality check, evaluated on the live command inputs.
   assign w_cmd_burst     = burst_t'(cmd_burst_i);
   assign w_cmd_size_mask = (AddrWidth'(1) << cmd_size_i) - AddrWidth'(1);
   assign w_cmd_aligned   = (cmd_addr_i & w_cmd_size_mask) == '0;
   assign w_wrap_len_ok   = (cmd_len_i == 8'd1) || (cmd_len_i == 8'd3) ||
                            (cmd_len_i == 8'd7) || (cmd_len_i == 8'd15);
   assign w_wrap_bad      = (w_cmd_burst == BURST_WRAP) && (!w_wrap_len_ok || !w_cmd_aligned);
   assign w_cmd_last_byte = (cmd_addr_i & ~w_cmd_size_mask)
                          + ((AddrWidth'(cmd_len_i) + AddrWidth'(1)) << cmd_size_i)
                          - AddrWidth'(1);
   assign w_page_err      = (CheckPage != 0) && (w_cmd_burst == BURST_INCR) &&
                            ((cmd_addr_i >> PAGE_BITS) != (w_cmd_last_byte >> PAGE_BITS));
   assign w_cmd_err       = (w_cmd_burst == BURST_RSVD) || (cmd_size_i > 3'(MaxSize)) ||
                            w_wrap_bad || w_page_err;
   assign w_step_burst    = ((w_cmd_burst == BURST_RSVD) || w_wrap_bad) ? BURST_INCR : w_cmd_burst;

   assign w_beat_fire = r_valid & beat_ready_i;
   assign w_cmd_ready = (r_state == ST_IDLE) | (w_beat_fire & r_last);
   assign w_cmd_fire  = cmd_valid_i & w_cmd_ready;
   assign cmd_ready_o = w_cmd_ready;

   axi_burst_next_addr #(
      .AddrWidth (AddrWidth)
   ) u_next_addr (
      .addr_i      (r_addr),
      .len_i       (r_len),
      .size_i      (r_size),
      .burst_i     (r_burst),
      .next_addr_o (w_next_addr)
   );

   // Next-state and next-output logic; a new command takes priority over retiring the last beat.
   always_comb begin
      w_state_d = r_state;
      w_valid_d = r_valid;
      w_addr_d  = r_addr;
      w_idx_d   = r_idx;
      w_last_d  = r_last;
      w_err_d   = r_err;
      w_len_d   = r_len;
      w_size_d  = r_size;
      w_burst_d = r_burst;
      if (w_cmd_fire) begin
         w_state_d = ST_BURST;
         w_valid_d = 1'b1;
         w_addr_d  = cmd_addr_i;
         w_idx_d   = 8'd0;
         w_last_d  = (cmd_len_i == 8'd0);
         w_err_d   = w_cmd_err;
         w_len_d   = cmd_len_i;
         w_size_d  = cmd_size_i;
         w_burst_d = w_step_burst;
      end else if (w_beat_fire) begin
         if (r_last) begin
            w_state_d = ST_IDLE;
            w_valid_d = 1'b0;
         end else begin
            w_addr_d = w_next_addr;
            w_idx_d  = r_idx + 8'd1;
            w_last_d = ((r_idx + 8'd1) == r_len);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= ST_IDLE;
         r_valid <= 1'b0;
         r_addr  <= '0;
         r_idx   <= 8'd0;
         r_last  <= 1'b0;
         r_err   <= 1'b0;
         r_len   <= 8'd0;
         r_size  <= 3'd0;
         r_burst <= BURST_FIXED;
      end else begin
         r_state <= w_state_d;
         r_valid <= w_valid_d;
         r_addr  <= w_addr_d;
         r_idx   <= w_idx_d;
         r_last  <= w_last_d;
         r_err   <= w_err_d;
         r_len   <= w_len_d;
         r_size  <= w_size_d;
         r_burst <= w_burst_d;
      end
   end

   assign beat_valid_o = r_valid;
   assign beat_addr_o  = r_addr;
   assign beat_idx_o   = r_idx;
   assign beat_last_o  = r_last;
   assign beat_err_o   = r_err;

endmodule

// File: tb/tb_axi_burst_addr_gen.sv
// Directed bench for axi_burst_addr_gen with hand-computed beat sequences.
module tb_axi_burst_addr_gen;

   localparam int unsigned AW = 64;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          cmd_valid_i;
   logic          cmd_ready_o;
   logic [AW-1:0] cmd_addr_i;
   logic [7:0]    cmd_len_i;
   logic [2:0]    cmd_size_i;
   logic [1:0]    cmd_burst_i;
   logic          beat_valid_o;
   logic          beat_ready_i;
   logic [AW-1:0] beat_addr_o;
   logic [7:0]    beat_idx_o;
   logic          beat_last_o;
   logic          beat_err_o;

   int n_assert = 0;
   int n_fail   = 0;

   axi_burst_addr_gen #(
      .AddrWidth (AW),
      .DataWidth (64),
      .CheckPage (1)
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .cmd_valid_i  (cmd_valid_i),
      .cmd_ready_o  (cmd_ready_o),
      .cmd_addr_i   (cmd_addr_i),
      .cmd_len_i    (cmd_len_i),
      .cmd_size_i   (cmd_size_i),
      .cmd_burst_i  (cmd_burst_i),
      .beat_valid_o (beat_valid_o),
      .beat_ready_i (beat_ready_i),
      .beat_addr_o  (beat_addr_o),
      .beat_idx_o   (beat_idx_o),
      .beat_last_o  (beat_last_o),
      .beat_err_o   (beat_err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic expect_beat(input string tag, input logic [63:0] addr, input int idx,
                              input logic last, input logic err);
      chk({tag, ".valid"}, 64'(beat_valid_o), 64'd1);
      chk({tag, ".addr"},  beat_addr_o, addr);
      chk({tag, ".idx"},   64'(beat_idx_o), 64'(idx));
      chk({tag, ".last"},  64'(beat_last_o), 64'(last));
      chk({tag, ".err"},   64'(beat_err_o), 64'(err));
   endtask

   task automatic issue(input logic [63:0] addr, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst);
      cmd_valid_i = 1'b1;
      cmd_addr_i  = addr;
      cmd_len_i   = len;
      cmd_size_i  = size;
      cmd_burst_i = burst;
      chk("issue.cmd_ready", 64'(cmd_ready_o), 64'd1);
      cycle();
      cmd_valid_i = 1'b0;
   endtask

   task automatic expect_idle(input string tag);
      chk({tag, ".valid"}, 64'(beat_valid_o), 64'd0);
      chk({tag, ".cmd_ready"}, 64'(cmd_ready_o), 64'd1);
   endtask

   initial begin
      rst_ni       = 1'b0;
      cmd_valid_i  = 1'b0;
      cmd_addr_i   = '0;
      cmd_len_i    = '0;
      cmd_size_i   = '0;
      cmd_burst_i  = '0;
      beat_ready_i = 1'b1;
      repeat (3) cycle();
      chk("rst.valid", 64'(beat_valid_o), 64'd0);
      chk("rst.addr",  beat_addr_o, 64'd0);
      chk("rst.idx",   64'(beat_idx_o), 64'd0);
      chk("rst.last",  64'(beat_last_o), 64'd0);
      chk("rst.err",   64'(beat_err_o), 64'd0);
      chk("rst.cmd_ready", 64'(cmd_ready_o), 64'd1);
      rst_ni = 1'b1;
      cycle();

      // INCR unaligned start
      issue(64'h1003, 8'd2, 3'd2, 2'b01);
      expect_beat("incr.b0", 64'h1003, 0, 1'b0, 1'b0);
      chk("incr.b0.cmd_ready", 64'(cmd_ready_o), 64'd0);
      cycle();
      expect_beat("incr.b1", 64'h1004, 1, 1'b0, 1'b0);
      cycle();
      expect_beat("incr.b2", 64'h1008, 2, 1'b1, 1'b0);
      cycle();
      expect_idle("incr.end");

      // WRAP
      issue(64'h38, 8'd3, 3'd3, 2'b10);
      expect_beat("wrap.b0", 64'h38, 0, 1'b0, 1'b0);
      cycle();
      expect_beat("wrap.b1", 64'h20, 1, 1'b0, 1'b0);
      cycle();
      expect_beat("wrap.b2", 64'h28, 2, 1'b0, 1'b0);
      cycle();
      expect_beat("wrap.b3", 64'h30, 3, 1'b1, 1'b0);
      cycle();
      expect_idle("wrap.end");

      // FIXED with stalls between every beat
      issue(64'h40, 8'd4, 3'd3, 2'b00);
      for (int i = 0; i < 5; i++) begin
         expect_beat($sformatf("fixed.b%0d", i), 64'h40, i, (i == 4), 1'b0);
         beat_ready_i = 1'b0;
         cycle();
         expect_beat($sformatf("fixed.stall%0d", i), 64'h40, i, (i == 4), 1'b0);
         beat_ready_i = 1'b1;
         cycle();
      end
      expect_idle("fixed.end");

      // Back-to-back bursts
      issue(64'h0, 8'd0, 3'd3, 2'b01);
      expect_beat("b2b.b0", 64'h0, 0, 1'b1, 1'b0);
      cmd_valid_i = 1'b1;
      cmd_addr_i  = 64'h100;
      cmd_len_i   = 8'd1;
      chk("b2b.cmd_ready_last", 64'(cmd_ready_o), 64'd1);
      cycle();
      cmd_valid_i = 1'b0;
      expect_beat("b2b.b1", 64'h100, 0, 1'b0, 1'b0);
      cycle();
      expect_beat("b2b.b2", 64'h108, 1, 1'b1, 1'b0);
      cycle();
      expect_idle("b2b.end");

      // INCR crossing a 4 KiB page
      issue(64'hFF8, 8'd1, 3'd3, 2'b01);
      expect_beat("page.b0", 64'hFF8, 0, 1'b0, 1'b1);
      cycle();
      expect_beat("page.b1", 64'h1000, 1, 1'b1, 1'b1);
      cycle();
      expect_idle("page.end");

      // WRAP with illegal length steps as INCR
      issue(64'h0, 8'd2, 3'd3, 2'b10);
      expect_beat("wraplen.b0", 64'h0, 0, 1'b0, 1'b1);
      cycle();
      expect_beat("wraplen.b1", 64'h8, 1, 1'b0, 1'b1);
      cycle();
      expect_beat("wraplen.b2", 64'h10, 2, 1'b1, 1'b1);
      cycle();
      expect_idle("wraplen.end");

      // Size wider than the 64-bit bus
      issue(64'h0, 8'd0, 3'd4, 2'b01);
      expect_beat("size.b0", 64'h0, 0, 1'b1, 1'b1);
      cycle();
      expect_idle("size.end");

      // Reserved burst type
      issue(64'h10, 8'd1, 3'd2, 2'b11);
      expect_beat("rsvd.b0", 64'h10, 0, 1'b0, 1'b1);
      cycle();
      expect_beat("rsvd.b1", 64'h14, 1, 1'b1, 1'b1);
      cycle();
      expect_idle("rsvd.end");

      // Reset in the middle of a burst
      issue(64'h2000, 8'd7, 3'd3, 2'b01);
      cycle();
      cycle();
      expect_beat("mid.b2", 64'h2010, 2, 1'b0, 1'b0);
      rst_ni = 1'b0;
      #1;
      chk("mid.rst.valid", 64'(beat_valid_o), 64'd0);
      chk("mid.rst.addr",  beat_addr_o, 64'd0);
      chk("mid.rst.idx",   64'(beat_idx_o), 64'd0);
      chk("mid.rst.last",  64'(beat_last_o), 64'd0);
      chk("mid.rst.cmd_ready", 64'(cmd_ready_o), 64'd1);
      cycle();
      rst_ni = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         expect_idle($sformatf("mid.post%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/axi_burst_addr_gen.md
Name: axi_burst_addr_gen

Overview:
Parametrised AXI4 burst address generator. Accepts one AW/AR-style command (addr, len, size, burst) and emits one address per beat over a valid/ready stream, covering FIXED, INCR and WRAP. Flags protocol-illegal commands so downstream slaves can return SLVERR. Shared by the AXI slave adapters and the AXI-to-native bridges; it replaces the per-bridge ad-hoc beat counters.

Parameters:
AddrWidth, 64, width of command and beat addresses
DataWidth, 64, bus data width in bits; power of two, 8..1024; max legal size = log2(DataWidth/8)
CheckPage, 1, if 1, INCR bursts crossing a 4 KiB boundary are flagged as errors

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command ready
cmd_addr_i  in  AddrWidth  start address
cmd_len_i  in  8  beats minus one
cmd_size_i  in  3  log2 bytes per beat
cmd_burst_i  in  2  burst type (FIXED/INCR/WRAP; 2'b11 reserved)
beat_valid_o  out  1  beat valid
beat_ready_i  in  1  beat ready
beat_addr_o  out  AddrWidth  beat address
beat_idx_o  out  8  beat index, 0..len
beat_last_o  out  1  final beat of burst
beat_err_o  out  1  command illegal; constant for the whole burst

Behaviour:
- One clock, clk_i. Reset is asynchronous and active-low on rst_ni. Reset values: beat_valid_o=0, beat_addr_o=0, beat_idx_o=0, beat_last_o=0, beat_err_o=0. State=IDLE, so cmd_ready_o=1.
- States: IDLE and BURST.
- cmd_ready_o = (state==IDLE) | (beat_valid_o & beat_ready_i & beat_last_o). This gives back-to-back bursts with no bubble.
- Command handshake in cycle N: registers addr/len/size/burst and err. In cycle N+1: beat_valid_o=1, beat_addr_o=cmd_addr_i (unaligned kept), beat_idx_o=0, beat_last_o=(len==0). State=BURST.
- Beat handshake (valid & ready) with last=0: idx += 1, last <= (idx+1 == len), and addr updates:
  - FIXED: unchanged.
  - INCR: (addr & ~((1<<size)-1)) + (1<<size).
  - WRAP: bound = addr & ~(((len+1)<<size)-1); next = bound | ((addr + (1<<size)) & (((len+1)<<size)-1)).
- Beat handshake with last=1:
  - if cmd_valid_i, the new command loads as in cycle N+1 above, and beat_valid_o stays 1;
  - else beat_valid_o<=0 and state=IDLE.
- beat_valid_o=1 with beat_ready_i=0: all beat outputs held stable.
- Address arithmetic is modulo 2^AddrWidth; wrap-around at the top of the address space is not flagged.
- err is computed combinationally at command accept and set if any of:
  - burst==2'b11;
  - size > log2(DataWidth/8);
  - WRAP with len not in {1,3,7,15};
  - WRAP with addr not size-aligned;
  - CheckPage=1, INCR, and addr[AddrWidth-1:12] != last_byte[AddrWidth-1:12], where last_byte = aligned(addr) + ((len+1)<<size) - 1.
- An erroneous burst still emits exactly len+1 beats with beat_err_o=1. Reserved burst type and illegal WRAP use INCR stepping.
- Reset mid-burst: the burst is discarded; outputs return to reset values in the same cycle.

Decomposition:
- Add to axi_common: typedef len_t (logic [7:0]), typedef size_t (logic [2:0]), localparam PAGE_BITS = 12. Reuse burst_t and resp_t there.
- One combinational sub-module, axi_burst_next_addr (inputs addr, len, size, burst; output next address). It is reused by the write-path bridges.

Test Plan:
- INCR addr=0x1003, size=2, len=2, ready=1 -> beats 0x1003, 0x1004, 0x1008; idx 0,1,2; last only on the third beat; err=0.
- WRAP addr=0x38, size=3, len=3 -> beats 0x38, 0x20, 0x28, 0x30; last on 0x30; err=0.
- FIXED addr=0x40, size=3, len=4, with beat_ready_i toggling 1,0,1,0 -> five beats all 0x40; outputs held stable in every stall cycle.
- Back-to-back: INCR len=0 addr=0x0, and cmd_valid_i held with a second INCR len=1 addr=0x100 -> cmd_ready_o=1 on the last-beat handshake; beats 0x0, 0x100, 0x108 in consecutive cycles with no bubble.
- Errors:
  - INCR addr=0xFF8, size=3, len=1 -> beats 0xFF8, 0x1000, both err=1.
  - WRAP len=2 -> three beats with err=1.
  - DataWidth=64 with size=4 -> err=1.
- rst_ni low during beat 2 of a len=7 burst -> beat_valid_o=0 immediately; after release cmd_ready_o=1 and no stale beats.
